// File: rtl/spi_sipo_slave.sv
// SPI slave shift block: oversampled serial-in/parallel-out receive and parallel-in/serial-out transmit.
// Optional macro SPI_SIPO_OVERRUN_EN: drop words completing while dout is unconsumed and raise sticky overrun.
module spi_sipo_slave #(
    parameter int WIDTH     = 8,
    parameter int MODE      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ss,
    input  logic             din,
    output logic             siso,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             overrun
);
    localparam logic          CPOL = ((MODE >> 1) & 1) != 0;
    localparam logic          CPHA = (MODE & 1) != 0;
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_tx(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] shift_rx(input logic [WIDTH-1:0] w, input logic b);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
    endfunction

    logic             sclk_s1_q, sclk_s2_q, sclk_p_q;
    logic             ss_s1_q, ss_s2_q, ss_p_q;
    logic             din_s1_q, din_s2_q;
    logic [1:0]       settle_q, settle_d;
    logic             armed_q, armed_d;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rx_q, rx_d, tx_q, tx_d, dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             siso_q, siso_d, first_q, first_d;
    logic             lead_edge, trail_edge, sample_edge, shift_edge, ss_fall, ss_rise;
    logic [WIDTH-1:0] tx_next;
`ifdef SPI_SIPO_OVERRUN_EN
    logic             overrun_q, overrun_d;
`endif

    assign lead_edge   = (sclk_p_q == CPOL) && (sclk_s2_q != CPOL);
    assign trail_edge  = (sclk_p_q != CPOL) && (sclk_s2_q == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ss_fall     = ss_p_q && !ss_s2_q;
    assign ss_rise     = !ss_p_q && ss_s2_q;
    assign tx_next     = shift_tx(tx_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        siso_d       = siso_q;
        first_d      = first_q;
        settle_d     = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        // A frame may only start once ss has been seen high with a flushed synchroniser.
        armed_d      = armed_q | ((settle_q == 2'd2) && ss_s2_q);
`ifdef SPI_SIPO_OVERRUN_EN
        overrun_d    = overrun_q;
`endif
        if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                siso_d = 1'b0;
                if (armed_q && ss_fall) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    tx_d    = tx_data;
                    first_d = CPHA;
                    siso_d  = CPHA ? 1'b0 : head(tx_data);
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    siso_d  = 1'b0;
                end else if (sample_edge) begin
                    rx_d = shift_rx(rx_q, din_s2_q);
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        tx_d    = tx_data;
                        first_d = 1'b1;
`ifdef SPI_SIPO_OVERRUN_EN
                        if (dout_valid_q && !dout_ready) begin
                            overrun_d = 1'b1;
                        end else begin
                            dout_d       = rx_d;
                            dout_valid_d = 1'b1;
                        end
`else
                        dout_d       = rx_d;
                        dout_valid_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (shift_edge) begin
                    // After a (re)load the first shift edge presents the head bit without advancing.
                    if (first_q) begin
                        siso_d  = head(tx_q);
                        first_d = 1'b0;
                    end else begin
                        tx_d   = tx_next;
                        siso_d = head(tx_next);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_q    <= CPOL;
            sclk_s2_q    <= CPOL;
            sclk_p_q     <= CPOL;
            ss_s1_q      <= 1'b1;
            ss_s2_q      <= 1'b1;
            ss_p_q       <= 1'b1;
            settle_q     <= 2'd0;
            armed_q      <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            siso_q       <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            sclk_s1_q    <= sclk;
            sclk_s2_q    <= sclk_s1_q;
            sclk_p_q     <= sclk_s2_q;
            ss_s1_q      <= ss;
            ss_s2_q      <= ss_s1_q;
            ss_p_q       <= ss_s2_q;
            settle_q     <= settle_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            siso_q       <= siso_d;
            first_q      <= first_d;
        end
    end

    always_ff @(posedge clk) begin
        din_s1_q <= din;
        din_s2_q <= din_s1_q;
        rx_q     <= rx_d;
        tx_q     <= tx_d;
    end

`ifdef SPI_SIPO_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= overrun_d;
    end
    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign siso       = siso_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
endmodule

// File: tb/tb_spi_sipo_slave.sv
// Bench for spi_sipo_slave: four instances covering modes, bit orders and widths, driven by a bit-level SPI master.
`timescale 1ns/1ps
module tb_spi_sipo_slave;
    localparam int NS = 4;
    localparam int WS [NS] = '{8, 8, 16, 8};
    localparam int MS [NS] = '{0, 3, 1, 2};
    localparam int LS [NS] = '{1, 0, 1, 0};
    localparam int HP [NS] = '{4, 4, 2, 4};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk_a [NS];
    logic        ss_a   [NS];
    logic        din_a  [NS];
    logic        rdy_a  [NS];
    logic [31:0] tx_a   [NS];
    logic [31:0] dout_a [NS];
    logic        vld_a  [NS];
    logic        siso_a [NS];
    logic        ovr_a  [NS];
    logic [7:0]  dout0, dout1, dout3;
    logic [15:0] dout2;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] got_q [NS][$];
    int          vcnt [NS];
    int          rcnt [NS];
    int          rise_cyc [NS];
    logic        vprev [NS];
    int          samp_cyc;
    logic [31:0] mw [4];
    logic [31:0] tw [4];
    logic [31:0] rw [4];

    spi_sipo_slave #(.WIDTH(8), .MODE(0), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .sclk(sclk_a[0]), .ss(ss_a[0]), .din(din_a[0]), .siso(siso_a[0]),
        .dout(dout0), .dout_valid(vld_a[0]), .dout_ready(rdy_a[0]), .tx_data(tx_a[0][7:0]), .overrun(ovr_a[0]));
    spi_sipo_slave #(.WIDTH(8), .MODE(3), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .sclk(sclk_a[1]), .ss(ss_a[1]), .din(din_a[1]), .siso(siso_a[1]),
        .dout(dout1), .dout_valid(vld_a[1]), .dout_ready(rdy_a[1]), .tx_data(tx_a[1][7:0]), .overrun(ovr_a[1]));
    spi_sipo_slave #(.WIDTH(16), .MODE(1), .MSB_FIRST(1)) u2 (
        .clk(clk), .rst(rst), .sclk(sclk_a[2]), .ss(ss_a[2]), .din(din_a[2]), .siso(siso_a[2]),
        .dout(dout2), .dout_valid(vld_a[2]), .dout_ready(rdy_a[2]), .tx_data(tx_a[2][15:0]), .overrun(ovr_a[2]));
    spi_sipo_slave #(.WIDTH(8), .MODE(2), .MSB_FIRST(0)) u3 (
        .clk(clk), .rst(rst), .sclk(sclk_a[3]), .ss(ss_a[3]), .din(din_a[3]), .siso(siso_a[3]),
        .dout(dout3), .dout_valid(vld_a[3]), .dout_ready(rdy_a[3]), .tx_data(tx_a[3][7:0]), .overrun(ovr_a[3]));

    assign dout_a[0] = {24'd0, dout0};
    assign dout_a[1] = {24'd0, dout1};
    assign dout_a[2] = {16'd0, dout2};
    assign dout_a[3] = {24'd0, dout3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer-side monitor: records every accepted word, valid-high cycles and rising edges.
    always @(negedge clk) begin
        for (int s = 0; s < NS; s++) begin
            if (vld_a[s] && rdy_a[s]) got_q[s].push_back(dout_a[s]);
            if (vld_a[s]) vcnt[s] = vcnt[s] + 1;
            if (vld_a[s] && !vprev[s]) begin
                rise_cyc[s] = cyc;
                rcnt[s] = rcnt[s] + 1;
            end
            vprev[s] = vld_a[s];
        end
    end

    function automatic logic [31:0] msk(input int s);
        return (32'd1 << WS[s]) - 32'd1;
    endfunction

    function automatic logic cpol_of(input int s);
        return ((MS[s] >> 1) & 1) != 0;
    endfunction

    task automatic clear_mon(input int s);
        got_q[s].delete();
        vcnt[s] = 0;
        rcnt[s] = 0;
        rise_cyc[s] = -1;
    endtask

    task automatic wait_hp(input int s);
        repeat (HP[s]) @(negedge clk);
    endtask

    task automatic bit_xfer(input int s, input logic b, output logic r);
        logic cpol;
        cpol = cpol_of(s);
        if ((MS[s] & 1) == 0) begin
            din_a[s] = b;
            wait_hp(s);
            r = siso_a[s];
            sclk_a[s] = ~cpol;
            samp_cyc = cyc;
            wait_hp(s);
            sclk_a[s] = cpol;
        end else begin
            wait_hp(s);
            sclk_a[s] = ~cpol;
            din_a[s] = b;
            wait_hp(s);
            r = siso_a[s];
            sclk_a[s] = cpol;
            samp_cyc = cyc;
        end
    endtask

    task automatic frame(input int s, input int nw, input int partial);
        logic r;
        int nb;
        int idx;
        @(negedge clk);
        tx_a[s] = tw[0];
        ss_a[s] = 1'b0;
        repeat (4) @(negedge clk);
        nb = (partial > 0) ? partial : WS[s];
        for (int w = 0; w < nw; w++) begin
            rw[w] = 32'd0;
            for (int k = 0; k < nb; k++) begin
                idx = (LS[s] != 0) ? WS[s] - 1 - k : k;
                bit_xfer(s, mw[w][idx], r);
                rw[w][idx] = r;
                if (k == 0 && w + 1 < nw) tx_a[s] = tw[w + 1];
            end
        end
        wait_hp(s);
        ss_a[s] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < NS; s++) begin
            checks++;
            if (dout_a[s] !== 32'd0 || vld_a[s] !== 1'b0 || siso_a[s] !== 1'b0 || ovr_a[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_u%0d dout=%h valid=%b siso=%b overrun=%b expected all zero",
                         s, dout_a[s], vld_a[s], siso_a[s], ovr_a[s]);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        clear_mon(0);
        mw[0] = 32'hA5;
        tw[0] = 32'h3C;
        frame(0, 1, 0);
        checks++;
        if (got_q[0].size() != 1 || got_q[0][0] !== 32'hA5) begin
            errors++;
            $display("FAIL t1_dout words=%0d first=%h expected 1 word a5", got_q[0].size(), got_q[0][0]);
        end
        checks++;
        if (rw[0] !== 32'h3C) begin
            errors++;
            $display("FAIL t1_miso got %h expected 3c", rw[0]);
        end
        checks++;
        if (vcnt[0] != 1) begin
            errors++;
            $display("FAIL t1_pulse valid high %0d cycles expected 1", vcnt[0]);
        end
        checks++;
        if (rise_cyc[0] - samp_cyc != 3) begin
            errors++;
            $display("FAIL t1_latency got %0d cycles expected 3", rise_cyc[0] - samp_cyc);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon(1);
        mw[0] = 32'h01; mw[1] = 32'h80;
        tw[0] = 32'h55; tw[1] = 32'hAA;
        frame(1, 2, 0);
        checks++;
        if (got_q[1].size() != 2 || got_q[1][0] !== 32'h01 || got_q[1][1] !== 32'h80) begin
            errors++;
            $display("FAIL t2_dout words=%0d got %h %h expected 01 80", got_q[1].size(), got_q[1][0], got_q[1][1]);
        end
        checks++;
        if (rw[0] !== 32'h55 || rw[1] !== 32'hAA) begin
            errors++;
            $display("FAIL t2_miso got %h %h expected 55 aa", rw[0], rw[1]);
        end
        checks++;
        if (vcnt[1] != 2 || rcnt[1] != 2) begin
            errors++;
            $display("FAIL t2_pulses valid cycles=%0d rises=%0d expected 2 and 2", vcnt[1], rcnt[1]);
        end
    endtask

    task automatic test_partial();
        clear_mon(0);
        mw[0] = 32'hFF;
        tw[0] = 32'h00;
        frame(0, 1, 5);
        mw[0] = 32'h12;
        tw[0] = $urandom & msk(0);
        frame(0, 1, 0);
        checks++;
        if (got_q[0].size() != 1 || got_q[0][0] !== 32'h12) begin
            errors++;
            $display("FAIL t3_dout words=%0d first=%h expected 1 word 12", got_q[0].size(), got_q[0][0]);
        end
        checks++;
        if (rw[0] !== tw[0]) begin
            errors++;
            $display("FAIL t3_miso got %h expected %h", rw[0], tw[0]);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] exp_word;
        logic        exp_ovr;
`ifdef SPI_SIPO_OVERRUN_EN
        exp_word = 32'h11;
        exp_ovr  = 1'b1;
`else
        exp_word = 32'h22;
        exp_ovr  = 1'b0;
`endif
        @(posedge clk);
        #1 rdy_a[0] = 1'b0;
        clear_mon(0);
        mw[0] = 32'h11; mw[1] = 32'h22;
        tw[0] = $urandom & msk(0); tw[1] = $urandom & msk(0);
        frame(0, 2, 0);
        checks++;
        if (dout_a[0] !== exp_word || ovr_a[0] !== exp_ovr) begin
            errors++;
            $display("FAIL t4_hold dout=%h overrun=%b expected %h %b", dout_a[0], ovr_a[0], exp_word, exp_ovr);
        end
        checks++;
        if (vld_a[0] !== 1'b1 || rcnt[0] != 1) begin
            errors++;
            $display("FAIL t4_valid valid=%b rises=%0d expected 1 and 1", vld_a[0], rcnt[0]);
        end
        @(posedge clk);
        #1 rdy_a[0] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (vld_a[0] !== 1'b0 || got_q[0].size() != 1 || got_q[0][0] !== exp_word) begin
            errors++;
            $display("FAIL t4_accept valid=%b words=%0d first=%h expected 0 1 %h",
                     vld_a[0], got_q[0].size(), got_q[0][0], exp_word);
        end
        checks++;
        if (ovr_a[0] !== exp_ovr) begin
            errors++;
            $display("FAIL t4_sticky overrun=%b expected %b", ovr_a[0], exp_ovr);
        end
    endtask

    task automatic test_reset_midframe();
        logic r;
        clear_mon(0);
        @(negedge clk);
        tx_a[0] = 32'h96;
        ss_a[0] = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) bit_xfer(0, 1'($urandom_range(0, 1)), r);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dout_a[0] !== 32'd0 || vld_a[0] !== 1'b0 || siso_a[0] !== 1'b0 || ovr_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL t5_reset dout=%h valid=%b siso=%b overrun=%b expected all zero",
                     dout_a[0], vld_a[0], siso_a[0], ovr_a[0]);
        end
        for (int k = 0; k < 13; k++) bit_xfer(0, 1'($urandom_range(0, 1)), r);
        wait_hp(0);
        checks++;
        if (vcnt[0] != 0 || dout_a[0] !== 32'd0) begin
            errors++;
            $display("FAIL t5_ignore valid cycles=%0d dout=%h expected 0 and 0", vcnt[0], dout_a[0]);
        end
        ss_a[0] = 1'b1;
        repeat (8) @(negedge clk);
        mw[0] = $urandom & msk(0);
        tw[0] = $urandom & msk(0);
        frame(0, 1, 0);
        checks++;
        if (got_q[0].size() != 1 || got_q[0][0] !== mw[0] || rw[0] !== tw[0]) begin
            errors++;
            $display("FAIL t5_resume words=%0d dout=%h miso=%h expected 1 %h %h",
                     got_q[0].size(), got_q[0][0], rw[0], mw[0], tw[0]);
        end
    endtask

    task automatic test_wide();
        clear_mon(2);
        mw[0] = 32'hBEEF;
        tw[0] = $urandom & msk(2);
        frame(2, 1, 0);
        checks++;
        if (got_q[2].size() != 1 || got_q[2][0] !== 32'hBEEF) begin
            errors++;
            $display("FAIL t6_dout words=%0d first=%h expected 1 word beef", got_q[2].size(), got_q[2][0]);
        end
        checks++;
        if (rise_cyc[2] - samp_cyc != 3) begin
            errors++;
            $display("FAIL t6_latency got %0d cycles expected 3", rise_cyc[2] - samp_cyc);
        end
    endtask

    task automatic test_random();
        int s;
        int nw;
        for (int it = 0; it < 8; it++) begin
            s  = it % NS;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                mw[w] = $urandom & msk(s);
                tw[w] = $urandom & msk(s);
            end
            clear_mon(s);
            frame(s, nw, 0);
            checks++;
            if (got_q[s].size() != nw) begin
                errors++;
                $display("FAIL rand_count u%0d got %0d words expected %0d", s, got_q[s].size(), nw);
            end else begin
                for (int w = 0; w < nw; w++) begin
                    checks++;
                    if (got_q[s][w] !== mw[w]) begin
                        errors++;
                        $display("FAIL rand_dout u%0d word %0d got %h expected %h", s, w, got_q[s][w], mw[w]);
                    end
                end
            end
            // The 16-bit instance runs at 4x oversampling, too fast for the MISO return path.
            if (s != 2) begin
                for (int w = 0; w < nw; w++) begin
                    checks++;
                    if (rw[w] !== tw[w]) begin
                        errors++;
                        $display("FAIL rand_miso u%0d word %0d got %h expected %h", s, w, rw[w], tw[w]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int s = 0; s < NS; s++) begin
            sclk_a[s] = cpol_of(s);
            ss_a[s]   = 1'b1;
            din_a[s]  = 1'b0;
            rdy_a[s]  = 1'b1;
            tx_a[s]   = 32'd0;
            vprev[s]  = 1'b0;
            clear_mon(s);
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_partial();
        test_overrun();
        test_reset_midframe();
        test_wide();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
